// File: rtl/lc3_pkg.sv
// Shared types for the LC-3 control unit: FSM state encoding, datapath
// mux/ALU select encodings and the opcode values the decoder dispatches on.
// No ports; imported by lc3_control_unit and its sub-modules.
package lc3_pkg;

  typedef enum logic [4:0] {
    ST_IDLE,
    ST_S18, ST_S33, ST_S35, ST_S32,
    ST_S01, ST_S05, ST_S09,
    ST_S00, ST_S22,
    ST_S12,
    ST_S04, ST_S21,
    ST_S06, ST_S25, ST_S27,
    ST_S07, ST_S23, ST_S16,
    ST_P1,  ST_P2
  } state_e;

  typedef enum logic [1:0] {PCMUX_PC1 = 2'b00, PCMUX_BUS = 2'b01, PCMUX_ADDER = 2'b10} pcmux_e;
  typedef enum logic [1:0] {ADDR2_ZERO = 2'b00, ADDR2_SEXT6 = 2'b01,
                            ADDR2_SEXT9 = 2'b10, ADDR2_SEXT11 = 2'b11} addr2mux_e;
  typedef enum logic [1:0] {ALUK_ADD = 2'b00, ALUK_AND = 2'b01,
                            ALUK_NOT = 2'b10, ALUK_PASSA = 2'b11} aluk_e;
  typedef enum logic {ADDR1_PC = 1'b0, ADDR1_SR1 = 1'b1} addr1mux_e;
  typedef enum logic {DRMUX_IR11_9 = 1'b0, DRMUX_R7 = 1'b1} drmux_e;
  typedef enum logic {SR1MUX_IR11_9 = 1'b0, SR1MUX_IR8_6 = 1'b1} sr1mux_e;
  typedef enum logic {SR2MUX_SR2 = 1'b0, SR2MUX_SEXT5 = 1'b1} sr2mux_e;

  typedef enum logic [3:0] {
    OP_BR    = 4'b0000,
    OP_ADD   = 4'b0001,
    OP_JSR   = 4'b0100,
    OP_AND   = 4'b0101,
    OP_LDR   = 4'b0110,
    OP_STR   = 4'b0111,
    OP_NOT   = 4'b1001,
    OP_JMP   = 4'b1100,
    OP_PAUSE = 4'b1101
  } opcode_e;

  // States that hold for MEM_WAIT cycles while the SRAM access completes.
  function automatic logic is_mem_wait(input state_e s);
    return (s == ST_S33) || (s == ST_S25) || (s == ST_S16);
  endfunction

endpackage

// File: rtl/lc3_wait_counter.sv
// Down-counter that times multi-cycle SRAM states.
// Ports: load_i/load_val_i preset the count, dec_i steps it down,
// done_o is high while the count is zero. Async active-low reset clears it.
module lc3_wait_counter #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             done_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/lc3_control_unit.sv
// LC-3 Moore sequencing FSM: fetch / decode / execute, one instruction at a time.
// Inputs: Clk, Reset (async active-low), Run, Continue, Opcode, IR_5, BEN.
// Outputs: register loads, bus gates, mux/ALU selects, active-low SRAM strobes.
module lc3_control_unit
  import lc3_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic       MIO_EN,
  output logic [1:0] PCMUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_OE,
  output logic       Mem_WE
);

  localparam int unsigned CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

  state_e state_q, state_d;
  logic   cnt_done;
  logic   cnt_load;
  logic   cnt_dec;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Preset on entry to a wait state so the state lasts exactly MEM_WAIT cycles.
  assign cnt_load = is_mem_wait(state_d) && (state_d != state_q);
  assign cnt_dec  = is_mem_wait(state_q);

  lc3_wait_counter #(.WIDTH(CW)) u_wait (
    .Clk        (Clk),
    .Reset      (Reset),
    .load_i     (cnt_load),
    .load_val_i (CW'(MEM_WAIT - 1)),
    .dec_i      (cnt_dec),
    .done_o     (cnt_done)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (Run) state_d = ST_S18;
      ST_S18:  state_d = ST_S33;
      ST_S33:  if (cnt_done) state_d = ST_S35;
      ST_S35:  state_d = ST_S32;
      ST_S32: begin
        case (Opcode)
          OP_ADD:   state_d = ST_S01;
          OP_AND:   state_d = ST_S05;
          OP_NOT:   state_d = ST_S09;
          OP_BR:    state_d = ST_S00;
          OP_JMP:   state_d = ST_S12;
          OP_JSR:   state_d = ST_S04;
          OP_LDR:   state_d = ST_S06;
          OP_STR:   state_d = ST_S07;
          OP_PAUSE: state_d = ST_P1;
          default:  state_d = ST_S18;  // unimplemented opcodes execute as NOP
        endcase
      end
      ST_S00:  state_d = BEN ? ST_S22 : ST_S18;
      ST_S04:  state_d = ST_S21;
      ST_S06:  state_d = ST_S25;
      ST_S25:  if (cnt_done) state_d = ST_S27;
      ST_S07:  state_d = ST_S23;
      ST_S23:  state_d = ST_S16;
      ST_S16:  if (cnt_done) state_d = ST_S18;
      ST_P1:   if (Continue) state_d = ST_P2;
      // Wait for button release so one press advances one instruction.
      ST_P2:   if (!Continue) state_d = ST_S18;
      ST_S01, ST_S05, ST_S09, ST_S22, ST_S12, ST_S21, ST_S27: state_d = ST_S18;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0; LD_BEN = 1'b0;
    LD_CC = 1'b0; LD_REG = 1'b0; LD_PC = 1'b0; LD_LED = 1'b0;
    GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
    DRMUX = DRMUX_IR11_9; SR1MUX = SR1MUX_IR11_9; SR2MUX = SR2MUX_SR2;
    ADDR1MUX = ADDR1_PC; MIO_EN = 1'b0;
    PCMUX = PCMUX_PC1; ADDR2MUX = ADDR2_ZERO; ALUK = ALUK_ADD;
    Mem_OE = 1'b1; Mem_WE = 1'b1;
    unique case (state_q)
      ST_S18: begin GatePC = 1'b1; LD_MAR = 1'b1; PCMUX = PCMUX_PC1; LD_PC = 1'b1; end
      ST_S33, ST_S25: begin
        Mem_OE = 1'b0; MIO_EN = 1'b1;
        LD_MDR = cnt_done;  // capture read data only once the access has settled
      end
      ST_S35: begin GateMDR = 1'b1; LD_IR = 1'b1; end
      ST_S32: LD_BEN = 1'b1;
      ST_S01, ST_S05, ST_S09: begin
        SR1MUX = SR1MUX_IR8_6; SR2MUX = IR_5; DRMUX = DRMUX_IR11_9;
        GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        ALUK = (state_q == ST_S01) ? ALUK_ADD : (state_q == ST_S05) ? ALUK_AND : ALUK_NOT;
      end
      ST_S22: begin ADDR1MUX = ADDR1_PC; ADDR2MUX = ADDR2_SEXT9; PCMUX = PCMUX_ADDER; LD_PC = 1'b1; end
      ST_S12: begin
        SR1MUX = SR1MUX_IR8_6; ADDR1MUX = ADDR1_SR1; ADDR2MUX = ADDR2_ZERO;
        PCMUX = PCMUX_ADDER; LD_PC = 1'b1;
      end
      ST_S04: begin DRMUX = DRMUX_R7; GatePC = 1'b1; LD_REG = 1'b1; end
      ST_S21: begin ADDR1MUX = ADDR1_PC; ADDR2MUX = ADDR2_SEXT11; PCMUX = PCMUX_ADDER; LD_PC = 1'b1; end
      ST_S06, ST_S07: begin
        SR1MUX = SR1MUX_IR8_6; ADDR1MUX = ADDR1_SR1; ADDR2MUX = ADDR2_SEXT6;
        GateMARMUX = 1'b1; LD_MAR = 1'b1;
      end
      ST_S27: begin GateMDR = 1'b1; DRMUX = DRMUX_IR11_9; LD_REG = 1'b1; LD_CC = 1'b1; end
      // Store source register IR[11:9] passes through the ALU into MDR.
      ST_S23: begin SR1MUX = SR1MUX_IR11_9; ALUK = ALUK_PASSA; GateALU = 1'b1; MIO_EN = 1'b0; LD_MDR = 1'b1; end
      ST_S16: Mem_WE = 1'b0;
      ST_P1:  LD_LED = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lc3_control_unit.sv
module tb_lc3_control_unit;

  localparam int MW = 3;
  localparam int FL = MW + 3;  // fetch prefix length in cycles

  logic       Clk = 1'b0;
  logic       Reset, Run, Continue, IR_5, BEN;
  logic [3:0] Opcode;
  logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic       GatePC, GateMDR, GateALU, GateMARMUX;
  logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic       Mem_OE, Mem_WE;

  always #5 Clk = ~Clk;

  lc3_control_unit #(.MEM_WAIT(MW)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .Opcode(Opcode),
    .IR_5(IR_5), .BEN(BEN),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN), .LD_CC(LD_CC),
    .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX), .MIO_EN(MIO_EN),
    .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
  );

  typedef struct packed {
    logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic drmux, sr1mux, sr2mux, addr1mux, mio_en;
    logic [1:0] pcmux, addr2mux, aluk;
    logic mem_oe, mem_we;
  } ctrl_t;

  ctrl_t act;
  assign act = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                GatePC, GateMDR, GateALU, GateMARMUX,
                DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN,
                PCMUX, ADDR2MUX, ALUK, Mem_OE, Mem_WE};

  int checks = 0;
  int failures = 0;

  ctrl_t exp_q[$];
  string tag_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic ctrl_t idle_word();
    ctrl_t c = '0;
    c.mem_oe = 1'b1;
    c.mem_we = 1'b1;
    return c;
  endfunction

  task automatic push(input string t, input ctrl_t c);
    exp_q.push_back(c);
    tag_q.push_back(t);
  endtask

  // Expected control word sequence for one whole instruction, fetch included.
  task automatic build_instr(input logic [3:0] op, input logic ir5, input logic ben,
                             input int n1, input int m);
    ctrl_t c;
    c = idle_word(); c.gate_pc = 1; c.ld_mar = 1; c.ld_pc = 1; push("S18", c);
    for (int k = 0; k < MW; k++) begin
      c = idle_word(); c.mem_oe = 0; c.mio_en = 1; c.ld_mdr = (k == MW - 1); push("S33", c);
    end
    c = idle_word(); c.gate_mdr = 1; c.ld_ir = 1; push("S35", c);
    c = idle_word(); c.ld_ben = 1; push("S32", c);
    case (op)
      4'b0001, 4'b0101, 4'b1001: begin
        c = idle_word(); c.sr1mux = 1; c.sr2mux = ir5; c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1;
        c.aluk = (op == 4'b0001) ? 2'd0 : (op == 4'b0101) ? 2'd1 : 2'd2;
        push("ALU_EXEC", c);
      end
      4'b0000: begin
        push("S00", idle_word());
        if (ben) begin
          c = idle_word(); c.addr2mux = 2'b10; c.pcmux = 2'b10; c.ld_pc = 1; push("S22", c);
        end
      end
      4'b1100: begin
        c = idle_word(); c.sr1mux = 1; c.addr1mux = 1; c.pcmux = 2'b10; c.ld_pc = 1; push("S12", c);
      end
      4'b0100: begin
        c = idle_word(); c.drmux = 1; c.gate_pc = 1; c.ld_reg = 1; push("S04", c);
        c = idle_word(); c.addr2mux = 2'b11; c.pcmux = 2'b10; c.ld_pc = 1; push("S21", c);
      end
      4'b0110, 4'b0111: begin
        c = idle_word(); c.sr1mux = 1; c.addr1mux = 1; c.addr2mux = 2'b01;
        c.gate_marmux = 1; c.ld_mar = 1; push("EA_CALC", c);
        if (op == 4'b0110) begin
          for (int k = 0; k < MW; k++) begin
            c = idle_word(); c.mem_oe = 0; c.mio_en = 1; c.ld_mdr = (k == MW - 1); push("S25", c);
          end
          c = idle_word(); c.gate_mdr = 1; c.ld_reg = 1; c.ld_cc = 1; push("S27", c);
        end else begin
          c = idle_word(); c.aluk = 2'b11; c.gate_alu = 1; c.ld_mdr = 1; push("S23", c);
          for (int k = 0; k < MW; k++) begin
            c = idle_word(); c.mem_we = 0; push("S16", c);
          end
        end
      end
      4'b1101: begin
        for (int k = 0; k <= n1; k++) begin
          c = idle_word(); c.ld_led = 1; push("P1", c);
        end
        for (int k = 0; k < m; k++) push("P2", idle_word());
      end
      default: ;
    endcase
  endtask

  // For PAUSE: Continue low for n1 cycles of P1, then high for m cycles.
  task automatic run_instr(input logic [3:0] op, input logic ir5, input logic ben,
                           input int n1, input int m);
    ctrl_t e;
    string t;
    build_instr(op, ir5, ben, n1, m);
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge Clk);
      Opcode = op; IR_5 = ir5; BEN = ben;
      Run = 1'($urandom);
      if (op == 4'b1101) Continue = (i >= FL + n1) && (i < FL + n1 + m);
      else               Continue = 1'($urandom);
      #1;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_val($sformatf("op%b_c%0d_%s", op, i, t), {7'b0, act}, {7'b0, e});
    end
  endtask

  ctrl_t w;

  initial begin
    Reset = 0; Run = 0; Continue = 0; IR_5 = 0; BEN = 0; Opcode = 4'b0000;
    #1;
    check_val("reset_default", {7'b0, act}, {7'b0, idle_word()});
    @(negedge Clk); Reset = 1;
    repeat (2) begin
      @(negedge Clk); Run = 0; Continue = 1; #1;
      check_val("idle_no_run", {7'b0, act}, {7'b0, idle_word()});
    end
    @(negedge Clk); Run = 1; #1;
    check_val("idle_run_moore", {7'b0, act}, {7'b0, idle_word()});
    @(negedge Clk); Run = 0; #1;
    w = idle_word(); w.gate_pc = 1; w.ld_mar = 1; w.ld_pc = 1;
    check_val("first_S18", {7'b0, act}, {7'b0, w});
    @(negedge Clk); #1;
    w = idle_word(); w.mem_oe = 0; w.mio_en = 1;
    check_val("first_S33", {7'b0, act}, {7'b0, w});
    @(negedge Clk); Reset = 0; #1;
    check_val("async_rst_mid_S33", {7'b0, act}, {7'b0, idle_word()});
    @(negedge Clk); #1;
    check_val("rst_held", {7'b0, act}, {7'b0, idle_word()});
    Reset = 1;
    @(negedge Clk); Run = 0; #1;
    check_val("idle_after_rst", {7'b0, act}, {7'b0, idle_word()});
    @(negedge Clk); Run = 1; #1;
    check_val("idle_run_again", {7'b0, act}, {7'b0, idle_word()});

    // Directed instructions, back to back.
    run_instr(4'b0001, 1'b1, 1'b0, 0, 1);  // ADD immediate
    run_instr(4'b0101, 1'b0, 1'b1, 0, 1);  // AND register
    run_instr(4'b0000, 1'b0, 1'b1, 0, 1);  // BR taken
    run_instr(4'b0000, 1'b1, 1'b0, 0, 1);  // BR not taken
    run_instr(4'b0110, 1'b0, 1'b0, 0, 1);  // LDR
    run_instr(4'b0111, 1'b1, 1'b1, 0, 1);  // STR
    run_instr(4'b0100, 1'b0, 1'b0, 0, 1);  // JSR
    run_instr(4'b1100, 1'b0, 1'b1, 0, 1);  // JMP
    run_instr(4'b1101, 1'b0, 1'b0, 5, 4);  // PAUSE, long press
    run_instr(4'b1111, 1'b1, 1'b1, 0, 1);  // NOP opcode
    run_instr(4'b1001, 1'b0, 1'b0, 0, 1);  // NOT

    for (int n = 0; n < 60; n++) begin
      run_instr(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lc3_control_unit.md
# lc3_control_unit

Moore-style sequencing FSM that drives every load, gate and mux select of the LC-3 datapath and the SRAM strobes, fetching, decoding and executing one instruction at a time. It sits beside the datapath in the CPU top level, consumes IR opcode fields and BEN from it, and takes the Run/Continue push-button inputs from the board-level I/O.

## Interface
- MEM_WAIT, 3: SRAM access cycles per read or write, ≥1.
- Clk  in  1  system clock, all state changes on rising edge.
- Reset  in  1  asynchronous, active-low; forces state IDLE.
- Run  in  1  start execution from IDLE (synchronous, level).
- Continue  in  1  releases a PAUSE instruction.
- Opcode  in  4  IR[15:12].
- IR_5  in  1  immediate-mode bit for ADD/AND.
- BEN  in  1  branch-enable from datapath register.
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1 each  register loads.
- GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers, at most one high.
- DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN  out  1 each  selects.
- PCMUX, ADDR2MUX, ALUK  out  2 each  selects.
- Mem_OE, Mem_WE  out  1 each  SRAM strobes, active-low.

## Operation
- Encodings: PCMUX 00 PC+1, 01 bus, 10 adder; ADDR2MUX 00 zero, 01 SEXT6, 10 SEXT9, 11 SEXT11; ADDR1MUX 0 PC, 1 SR1; ALUK 00 ADD, 01 AND, 10 NOT, 11 PASSA; DRMUX 0 IR[11:9], 1 R7; SR1MUX 0 IR[11:9], 1 IR[8:6]; SR2MUX 0 SR2, 1 SEXT5.
- Default every state: all loads/gates/selects 0, Mem_OE = Mem_WE = 1.
- IDLE: Run=1 → S18.
- S18: GatePC, LD_MAR, PCMUX=00, LD_PC → S33.
- S33 (MEM_WAIT cycles via wait counter): Mem_OE=0, MIO_EN=1; LD_MDR on last cycle only → S35.
- S35: GateMDR, LD_IR → S32.
- S32: LD_BEN; Opcode 0001 ADD→S01, 0101 AND→S05, 1001 NOT→S09, 0000 BR→S00, 1100 JMP→S12, 0100 JSR→S04, 0110 LDR→S06, 0111 STR→S07, 1101 PAUSE→P1; any other opcode → S18 (NOP).
- S01/S05/S09: SR1MUX=1, SR2MUX=IR_5, ALUK=00/01/10, GateALU, LD_REG, LD_CC, DRMUX=0 → S18.
- S00: BEN=1 → S22 else S18. S22: ADDR1MUX=0, ADDR2MUX=10, PCMUX=10, LD_PC → S18.
- S12: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=00, PCMUX=10, LD_PC → S18.
- S04: DRMUX=1, GatePC, LD_REG → S21: ADDR1MUX=0, ADDR2MUX=11, PCMUX=10, LD_PC → S18 (PC-relative JSR only).
- S06/S07: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=01, GateMARMUX, LD_MAR → S25 / S23.
- S25 (MEM_WAIT cycles): as S33 → S27: GateMDR, DRMUX=0, LD_REG, LD_CC → S18.
- S23: SR1MUX=0, ALUK=11, GateALU, MIO_EN=0, LD_MDR → S16 (MEM_WAIT cycles): Mem_WE=0 → S18.
- P1: LD_LED; Continue=1 → P2. P2: Continue=0 → S18 (one instruction per press).
- Run ignored outside IDLE; Continue ignored outside P1/P2.

## Timing
- Reset low, any state/any cycle: state IDLE, wait counter 0, all outputs at default within same cycle (combinational from state); Mem_OE/Mem_WE high, no spurious strobe.
- Outputs pure function of state (and IR_5/counter); no Mealy paths from Run/Continue/BEN.
- Fetch prefix S18..S32 = MEM_WAIT+3 cycles (6 at default).
- Totals at MEM_WAIT=3: ADD/AND/NOT/JMP 7; BR not-taken 7, taken 8; JSR 8; LDR 11; STR 11.
- Wait counter loads MEM_WAIT-1 on entry to S33/S25/S16, decrements, exits at 0; MEM_WAIT=1 gives single-cycle states with LD_MDR asserted that cycle.
- BEN loaded in S32, valid in S00 (one-cycle gap required by datapath).
- Continue held high through P1→P2 does not skip; release needed before next fetch.

## Structure
- Shared package lc3_pkg: state enum, PCMUX/ADDR2MUX/ALUK/DRMUX/SR1MUX encodings, opcode constants.
- Sub-module lc3_wait_counter (load, decrement, done) reused by S33/S25/S16.
- One always_ff for state/counter, one always_comb each for next-state and output decode.

## Test plan
- Reset low mid-S33 → next cycle state IDLE, Mem_OE=1, LD_MDR=0; Run=1 after release → S18 with GatePC=LD_MAR=LD_PC=1.
- Opcode 0001, IR_5=1 → S01 on cycle 6, SR2MUX=1, ALUK=00, LD_REG=LD_CC=1, back to S18 on cycle 7.
- Opcode 0000 with BEN=1 then BEN=0 → S22 with PCMUX=10, ADDR2MUX=10 (8 cycles); not-taken returns in 7 cycles, LD_PC never 1 in S00.
- Opcode 0110 → Mem_OE low exactly 3 cycles in S25, LD_MDR only on third, then GateMDR+LD_REG+LD_CC.
- Opcode 0111 → S23 LD_MDR with ALUK=11, then Mem_WE low exactly 3 cycles, Mem_OE stays 1.
- Opcode 1101, Continue low 5 cycles → held in P1, LD_LED=1; Continue 1 for 4 cycles → P2 held; Continue 0 → S18; unknown opcode 1111 → S32 then S18.
